// File: rtl/hamming_decoder_pipe.sv
// Two-stage pipelined Hamming(12,8) SEC decoder with valid/ready on both sides.
// Define HAMMING_DEC_STATS_EN to add saturating corrected/uncorrectable counters.
module hamming_decoder_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_codeword,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [3:0]  out_syndrome,
  output logic        out_corrected,
  output logic        out_uncorrectable
`ifdef HAMMING_DEC_STATS_EN
  ,
  input  logic        clr_cnt,
  output logic [15:0] cnt_corrected,
  output logic [15:0] cnt_uncorrectable
`endif
);

  logic        s1_valid;
  logic [11:0] s1_cw;
  logic [3:0]  s1_syn;
  logic [3:0]  in_syn;
  logic        s1_advance;
  logic        s2_load;
  logic [11:0] flip_mask;
  logic [11:0] fixed_cw;
  logic        dec_corrected;
  logic        dec_uncorrectable;
  logic [7:0]  dec_data;

  // Each mask selects the codeword bits whose 1-based position has syndrome bit k set.
  assign in_syn = {^(in_codeword & 12'hF80),
                   ^(in_codeword & 12'h878),
                   ^(in_codeword & 12'h666),
                   ^(in_codeword & 12'h555)};

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !rst && (!s1_valid || s1_advance);
  assign s2_load    = s1_valid && s1_advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cw  <= in_codeword;
        s1_syn <= in_syn;
      end
    end
  end

  always_comb begin
    flip_mask         = '0;
    dec_corrected     = 1'b0;
    dec_uncorrectable = 1'b0;
    if (s1_syn >= 4'd13) begin
      dec_uncorrectable = 1'b1;
    end else if (s1_syn != 4'd0) begin
      flip_mask     = 12'd1 << (s1_syn - 4'd1);
      dec_corrected = 1'b1;
    end
  end

  assign fixed_cw = s1_cw ^ flip_mask;
  assign dec_data = {fixed_cw[11], fixed_cw[10], fixed_cw[9], fixed_cw[8],
                     fixed_cw[6],  fixed_cw[5],  fixed_cw[4], fixed_cw[2]};

  // Result registers only change on a load, so a stalled result holds stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_syndrome      <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (s2_load) begin
      out_valid         <= 1'b1;
      out_data          <= dec_data;
      out_syndrome      <= s1_syn;
      out_corrected     <= dec_corrected;
      out_uncorrectable <= dec_uncorrectable;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  logic out_xfer;
  assign out_xfer = out_valid && out_ready;

  // Counting at the output transfer counts each word once however long it stalls.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (out_xfer) begin
      if (out_corrected && cnt_corrected != 16'hFFFF)
        cnt_corrected <= cnt_corrected + 16'd1;
      if (out_uncorrectable && cnt_uncorrectable != 16'hFFFF)
        cnt_uncorrectable <= cnt_uncorrectable + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Self-checking bench for hamming_decoder_pipe: directed table, backpressure,
// reset and optional statistics sequences, plus randomized traffic against a model.
module tb_hamming_decoder_pipe;

  typedef struct {
    logic [11:0] cw;
    logic [7:0]  data;
    logic [3:0]  syn;
    logic        corr;
    logic        unc;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] syn;
    logic       corr;
    logic       unc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_codeword;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_syndrome;
  logic        out_corrected;
  logic        out_uncorrectable;
`ifdef HAMMING_DEC_STATS_EN
  logic        clr_cnt;
  logic [15:0] cnt_corrected;
  logic [15:0] cnt_uncorrectable;
`endif

  int   n_vec = 0;
  int   n_miss = 0;
  int   n_xfer = 0;
  int   m_cc = 0;
  int   m_cu = 0;
  exp_t q[$];
  vec_t tbl[8];

  hamming_decoder_pipe dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_codeword(in_codeword),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_syndrome(out_syndrome),
    .out_corrected(out_corrected),
    .out_uncorrectable(out_uncorrectable)
`ifdef HAMMING_DEC_STATS_EN
    ,
    .clr_cnt(clr_cnt),
    .cnt_corrected(cnt_corrected),
    .cnt_uncorrectable(cnt_uncorrectable)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: syndrome is the XOR of the 1-based positions of all set bits.
  function automatic exp_t refDecode(input logic [11:0] cw);
    exp_t        e;
    int          s = 0;
    int          j = 0;
    logic [11:0] c = cw;
    for (int pos = 1; pos <= 12; pos++)
      if (cw[pos-1]) s = s ^ pos;
    e.syn  = 4'(s);
    e.corr = (s >= 1 && s <= 12);
    e.unc  = (s >= 13);
    if (e.corr) c[s-1] = ~c[s-1];
    e.data = '0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        e.data[j] = c[pos-1];
        j++;
      end
    end
    return e;
  endfunction

  function automatic logic [11:0] refEncode(input logic [7:0] d);
    logic [11:0] c = '0;
    int          j = 0;
    int          s = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[j];
        j++;
      end
    end
    for (int pos = 1; pos <= 12; pos++)
      if (c[pos-1]) s = s ^ pos;
    for (int k = 0; k < 4; k++)
      if (s[k]) c[(1 << k) - 1] = 1'b1;
    return c;
  endfunction

  function automatic logic [11:0] randomWord();
    logic [11:0] c = refEncode(8'($urandom));
    int          nerr = $urandom_range(0, 2);
    int          b0 = $urandom_range(0, 11);
    int          b1 = (b0 + 1 + $urandom_range(0, 10)) % 12;
    if (nerr >= 1) c[b0] = ~c[b0];
    if (nerr == 2) c[b1] = ~c[b1];
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check and update the model 1ns later.
  task automatic applyStimulus(input logic iv, input logic [11:0] cw, input logic ordy,
                               input logic clr, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid    = iv;
    in_codeword = cw;
    out_ready   = ordy;
`ifdef HAMMING_DEC_STATS_EN
    clr_cnt     = clr;
`endif
    #1;
    checkOutput("in_ready", in_ready, !(q.size() == 2 && !ordy));
`ifdef HAMMING_DEC_STATS_EN
    checkOutput("cnt_corrected", cnt_corrected, m_cc);
    checkOutput("cnt_uncorrectable", cnt_uncorrectable, m_cu);
`endif
    if (out_valid) begin
      if (q.size() == 0) begin
        checkOutput("spurious_out_valid", out_valid, 0);
      end else begin
        e = q[0];
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_syndrome", out_syndrome, e.syn);
        checkOutput("out_corrected", out_corrected, e.corr);
        checkOutput("out_uncorrectable", out_uncorrectable, e.unc);
        if (ordy) begin
          void'(q.pop_front());
          n_xfer++;
          if (!clr) begin
            if (e.corr && m_cc != 16'hFFFF) m_cc++;
            if (e.unc && m_cu != 16'hFFFF) m_cu++;
          end
        end
      end
    end
    if (clr) begin
      m_cc = 0;
      m_cu = 0;
    end
    acc = iv && in_ready;
    if (acc) q.push_back(refDecode(cw));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst         = 1'b1;
    in_valid    = 1'b1;
    in_codeword = 12'hA27;
    out_ready   = 1'b1;
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    @(negedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_syndrome", out_syndrome, 0);
    checkOutput("rst_flags", {out_corrected, out_uncorrectable}, 0);
`ifdef HAMMING_DEC_STATS_EN
    checkOutput("rst_cnt", {cnt_corrected, cnt_uncorrectable}, 0);
`endif
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    q.delete();
    m_cc = 0;
    m_cu = 0;
  endtask

  initial begin
    logic        acc;
    logic [11:0] w[4];
    int          idx;
    int          start_xfer;

    tbl[0] = '{12'hA27, 8'hA5, 4'd0,  1'b0, 1'b0};
    tbl[1] = '{12'hA07, 8'hA5, 4'd6,  1'b1, 1'b0};
    tbl[2] = '{12'hA26, 8'hA5, 4'd1,  1'b1, 1'b0};
    tbl[3] = '{12'h226, 8'h25, 4'd13, 1'b0, 1'b1};
    tbl[4] = '{12'h000, 8'h00, 4'd0,  1'b0, 1'b0};
    tbl[5] = '{12'h227, 8'hA5, 4'd12, 1'b1, 1'b0};
    tbl[6] = '{12'hFFF, 8'h7F, 4'd12, 1'b1, 1'b0};
    tbl[7] = '{12'hAA7, 8'hA5, 4'd8,  1'b1, 1'b0};

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_codeword = '0;
    out_ready   = 1'b0;
`ifdef HAMMING_DEC_STATS_EN
    clr_cnt     = 1'b0;
`endif
    doReset();

    $display("[TB] directed table");
    foreach (tbl[i]) begin
      applyStimulus(1'b1, tbl[i].cw, 1'b1, 1'b0, acc);
      checkOutput("tbl_accept", acc, 1);
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, acc);
      checkOutput("tbl_latency_early", out_valid, 0);
      @(negedge clk);
      #1;
      checkOutput("tbl_out_valid", out_valid, 1);
      checkOutput("tbl_data", out_data, tbl[i].data);
      checkOutput("tbl_syndrome", out_syndrome, tbl[i].syn);
      checkOutput("tbl_flags", {out_corrected, out_uncorrectable}, {tbl[i].corr, tbl[i].unc});
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0, acc);
    end

    $display("[TB] backpressure");
    doReset();
    for (int i = 0; i < 4; i++) w[i] = refEncode(8'($urandom));
    idx = 0;
    start_xfer = n_xfer;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(idx < 4, w[idx % 4], 1'b0, 1'b0, acc);
      if (c >= 2) checkOutput("bp_in_ready_low", in_ready, 0);
      if (acc) idx++;
    end
    checkOutput("bp_accepted_while_stalled", idx, 2);
    for (int c = 0; c < 20 && (idx < 4 || q.size() != 0); c++) begin
      applyStimulus(idx < 4, w[idx % 4], 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    checkOutput("bp_results_out", n_xfer - start_xfer, 4);

`ifdef HAMMING_DEC_STATS_EN
    $display("[TB] statistics");
    doReset();
    applyStimulus(1'b1, 12'hA07, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 12'hA26, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 12'h226, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 12'h227, 1'b1, 1'b0, acc);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 12'h000, 1'b1, 1'b0, acc);
    checkOutput("stats_corrected_3", cnt_corrected, 3);
    checkOutput("stats_uncorrectable_1", cnt_uncorrectable, 1);
    applyStimulus(1'b1, 12'hA07, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 12'h000, 1'b1, 1'b0, acc);
    checkOutput("stats_clr_xfer_valid", out_valid, 1);
    applyStimulus(1'b0, 12'h000, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 12'h000, 1'b1, 1'b0, acc);
    checkOutput("stats_clr_priority", {cnt_corrected, cnt_uncorrectable}, 0);
    applyStimulus(1'b1, 12'hA07, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 12'hA26, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 12'hA27, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 12'h226, 1'b0, 1'b0, acc);
    checkOutput("stats_pre_reset_nonzero", cnt_corrected != 0, 1);
    doReset();
`endif

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 12'hA07, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 12'hA26, 1'b0, 1'b0, acc);
    doReset();
    applyStimulus(1'b0, 12'h000, 1'b1, 1'b0, acc);
    checkOutput("rst_flushed_out_valid", out_valid, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), randomWord(), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31) == 0, acc);
    end
    for (int c = 0; c < 10 && q.size() != 0; c++)
      applyStimulus(1'b0, 12'h000, 1'b1, 1'b0, acc);
    checkOutput("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hamming_decoder_pipe.md
# hamming_decoder_pipe

Pipelined Hamming(12,8) single-error-correcting decoder that consumes the 12-bit codewords produced by the team's Hamming encoder stage and returns the 8-bit payload. It sits on the receive/readback path of the TBEC-RSC fabric design, after the protected storage or link and before the payload consumer. Flow control is valid/ready on both sides, with two register stages. Optional saturating error-statistics counters are included.

## Interface
- Parameters: none. Codeword width is fixed at 12 bits and data width at 8 bits.
- Reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_codeword` holds a codeword.
- `in_ready`  out  1  decoder accepts this cycle.
- `in_codeword`  in  12  codeword, bit layout below.
- `out_valid`  out  1  result is presented.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_data`  out  8  corrected payload.
- `out_syndrome`  out  4  syndrome of the codeword.
- `out_corrected`  out  1  a single-bit error was corrected. This covers parity-bit errors too.
- `out_uncorrectable`  out  1  syndrome was 13..15.
- `clr_cnt`  in  1  clears the statistics counters. Present only with `HAMMING_DEC_STATS_EN`.
- `cnt_corrected`  out  16  count of corrected codewords. Present only with `HAMMING_DEC_STATS_EN`.
- `cnt_uncorrectable`  out  16  count of uncorrectable codewords. Present only with `HAMMING_DEC_STATS_EN`.

## Operation
- Codeword layout uses 1-based position = index+1.
  - Parity bits: bit0=p0, bit1=p1, bit3=p2, bit7=p3.
  - Data bits: bit2=d0, bit4=d1, bit5=d2, bit6=d3, bit8=d4, bit9=d5, bit10=d6, bit11=d7.
- Syndrome bit k = XOR of all codeword bits whose 1-based position has bit k set, k=0..3.
  - s0 covers positions 1,3,5,7,9,11.
  - s1 covers positions 2,3,6,7,10,11.
  - s2 covers positions 4..7 and 12.
  - s3 covers positions 8..12.
- Stage 1 (on accept): register the codeword, the syndrome and the valid bit.
- Stage 2, decode by syndrome:
  - s=0: no error. Data is extracted unchanged; both flags are 0.
  - s=1..12: flip codeword bit s-1, extract data, `out_corrected`=1.
  - s=13..15: no flip; raw data is extracted; `out_uncorrectable`=1.
- Double-bit errors whose syndrome falls in 1..12 are miscorrected silently. This is an inherent limit of the code, not a bug.
- `out_syndrome` always carries the stage-1 syndrome.
- Handshakes:
  - A transfer occurs when valid and ready are both high.
  - `in_ready` = !s1_valid || s1 advances. s1 advances when !out_valid || `out_ready`.
  - Stage 2 loads when s1_valid and (!out_valid || `out_ready`).
  - `out_valid` clears on transfer with no new load.
  - While `out_valid`=1 and `out_ready`=0, `out_data`, `out_syndrome` and both flags hold stable.
  - Inputs are ignored while `in_ready`=0.
- Reset values: `out_valid`=0, `out_data`=0, `out_syndrome`=0, both flags 0, s1_valid=0, counters 0. `in_ready`=1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight words.
  - No transfer is reported for the cycle in which `rst`=1. During that cycle `in_ready` is forced to 0.

## Timing
- Latency: accept at edge N gives `out_valid`=1 after edge N+1. This is 2 cycles from `in_valid` sampled to result visible.
- Throughput: one codeword per cycle when `out_ready` is held high.
- Capacity: at most 2 words in flight. Under full backpressure `in_ready` drops in the cycle after stage 1 fills behind a stalled stage 2.
- Combinational paths:
  - `in_ready` has a path from `out_ready`. This is an accepted single-level path.
  - There is no path from input data to any output.
- Counters update on the edge where stage 2 presents a result at a transfer (`out_valid`&&`out_ready`). Each word is counted exactly once, regardless of stall length.

## Configuration
- `HAMMING_DEC_STATS_EN` defined:
  - `clr_cnt`, `cnt_corrected` and `cnt_uncorrectable` exist.
  - Counters saturate at 16'hFFFF.
  - `clr_cnt` has priority over a simultaneous increment: the counter becomes 0.
- `HAMMING_DEC_STATS_EN` not defined: the ports and counter logic are absent. Decode and handshake behaviour are identical.

## Test plan
- Clean word: data 0xA5 encodes to 0xA27. Apply 0xA27 -> `out_data`=0xA5, syndrome 0, both flags 0, result two cycles after accept.
- Data-bit error: apply 0xA07 (bit5/d2 flipped) -> `out_data`=0xA5, syndrome 6, `out_corrected`=1.
- Parity-bit error: apply 0xA26 (bit0 flipped) -> `out_data`=0xA5, syndrome 1, `out_corrected`=1.
- Uncorrectable: apply 0x226 (bits 0 and 11 flipped) -> syndrome 13, `out_uncorrectable`=1, `out_data`=0x25 (raw).
- Backpressure: stream 4 words with `out_ready`=0 for 5 cycles.
  - `in_ready` falls after 2 words are held and outputs stay stable.
  - After release, all 4 results emerge in order with no loss or duplication.
- Stats (`HAMMING_DEC_STATS_EN` defined): send 3 corrected and 1 uncorrectable word -> counters read 3/1. Then assert `clr_cnt` in the same cycle as a corrected transfer -> counters read 0/0. Reset mid-stream -> `out_valid`=0 next cycle and counters 0.
